// File: rtl/axi_burst_pkg.sv
// ============================================================================
// axi_burst_pkg: shared encodings and field widths for the AXI burst slave
// Rev 1.0
// ============================================================================
`default_nettype none

package axi_burst_pkg;

  localparam int ADDR_W = 8;
  localparam int LEN_W  = 4;
  localparam int ID_W   = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 5;

  localparam logic [CNT_W-1:0] MAX_BEATS = 5'd16;

  localparam int AR_ADDR_LSB = 8;
  localparam int AR_LEN_LSB  = 4;
  localparam int AW_ADDR_LSB = 4;

  localparam int RRESP_BIT     = 0;
  localparam int BRESP_ERR_BIT = 0;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_slave_ram.sv
// ============================================================================
// axi_slave_ram: DEPTH x 8 byte RAM, synchronous write, combinational read
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_slave_ram
  import axi_burst_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // Contents are never reset; the zero image only exists as a power-up value.
  if (INIT_ZERO != 0) begin : g_init_zero
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

    always @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
  end else begin : g_no_init
    logic [DATA_W-1:0] r_mem [DEPTH];

    always @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
  end

endmodule

`default_nettype wire

// File: rtl/axi_burst_slave.sv
// ============================================================================
// axi_burst_slave: independent read/write burst FSMs over a byte RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_burst_slave
  import axi_burst_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int INIT_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ARVALID,
  input  logic [15:0] AR_IN,
  output logic        ARREADY,
  output logic        RVALID,
  input  logic        RREADY,
  output logic        RLAST,
  output logic [8:0]  R_OUT,
  input  logic        AWVALID,
  input  logic [11:0] AW_IN,
  output logic        AWREADY,
  input  logic        WVALID,
  input  logic        WLAST,
  input  logic [7:0]  WDATA,
  output logic        WREADY,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [4:0]  BRESP
);

  r_state_t          r_rstate;
  logic              r_arready;
  logic              r_rvalid;
  logic              r_rlast;
  logic              r_rresp;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_raddr;
  logic [LEN_W-1:0]  r_rlen;
  logic [LEN_W-1:0]  r_rcnt;
  logic [ID_W-1:0]   r_arid;

  w_state_t          r_wstate;
  logic              r_awready;
  logic              r_wready;
  logic              r_bvalid;
  logic              r_werr;
  logic [ADDR_W-1:0] r_waddr;
  logic [ID_W-1:0]   r_wid;
  logic [CNT_W-1:0]  r_wcnt;

  logic [ADDR_W-1:0] w_ar_addr;
  logic [LEN_W-1:0]  w_ar_len;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_beat_ok;
  logic              w_mem_we;
  logic              w_unused_arid;

  assign w_ar_addr = AR_IN[AR_ADDR_LSB +: ADDR_W];
  assign w_ar_len  = AR_IN[AR_LEN_LSB +: LEN_W];

  // Idle fetches the burst's first byte; mid-burst prefetches the next one.
  assign w_rd_addr = (r_rstate == R_IDLE) ? w_ar_addr : r_raddr + 8'd1;
  assign w_beat_ok = (r_wcnt < MAX_BEATS);
  assign w_mem_we  = (r_wstate == W_DATA) && WVALID && w_beat_ok;

  // The read ID has no return channel here.
  assign w_unused_arid = ^r_arid;

  axi_slave_ram #(
    .DEPTH     (DEPTH),
    .INIT_ZERO (INIT_ZERO)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_waddr),
    .i_wdata (WDATA),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= 1'b0;
      r_rdata   <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_arid    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (ARVALID) begin
            r_raddr   <= w_ar_addr;
            r_rlen    <= w_ar_len;
            r_arid    <= AR_IN[ID_W-1:0];
            r_rcnt    <= '0;
            r_rdata   <= w_rd_data;
            r_rresp   <= 1'b0;
            r_rlast   <= (w_ar_len == '0);
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_rvalid && RREADY) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_raddr <= r_raddr + 8'd1;
              r_rdata <= w_rd_data;
              r_rcnt  <= r_rcnt + 4'd1;
              r_rlast <= ((r_rcnt + 4'd1) == r_rlen);
              // Sticky once the burst has crossed 0xFF -> 0x00.
              r_rresp <= r_rresp | (r_raddr == 8'hFF);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_werr    <= 1'b0;
      r_waddr   <= '0;
      r_wid     <= '0;
      r_wcnt    <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (AWVALID) begin
            r_waddr   <= AW_IN[AW_ADDR_LSB +: ADDR_W];
            r_wid     <= AW_IN[ID_W-1:0];
            r_werr    <= 1'b0;
            r_wcnt    <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            // Beats past MAX_BEATS are swallowed and only flag the error.
            if (w_beat_ok) begin
              r_waddr <= r_waddr + 8'd1;
              r_wcnt  <= r_wcnt + 5'd1;
            end else begin
              r_werr <= 1'b1;
            end
            if (WLAST) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RLAST   = r_rlast;
  assign R_OUT   = {r_rdata, r_rresp};
  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = {r_wid, r_werr};

endmodule

`default_nettype wire

// File: tb/tb_axi_burst_slave.sv
// ============================================================================
// tb_axi_burst_slave: table, directed and random checks against a byte model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_burst_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ARVALID = 1'b0;
  logic [15:0] AR_IN = '0;
  logic        ARREADY;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic        RLAST;
  logic [8:0]  R_OUT;
  logic        AWVALID = 1'b0;
  logic [11:0] AW_IN = '0;
  logic        AWREADY;
  logic        WVALID = 1'b0;
  logic        WLAST = 1'b0;
  logic [7:0]  WDATA = '0;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [4:0]  BRESP;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model_mem [256];

  typedef struct {
    logic [7:0] addr;
    logic [3:0] id;
    int         n;
    logic [7:0] d0;
    logic [7:0] step;
    logic [3:0] rlen;
    logic [4:0] exp_bresp;
    logic       exp_rresp_last;
  } vec_t;

  axi_burst_slave #(.DEPTH(256), .INIT_ZERO(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .ARVALID (ARVALID),
    .AR_IN   (AR_IN),
    .ARREADY (ARREADY),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .RLAST   (RLAST),
    .R_OUT   (R_OUT),
    .AWVALID (AWVALID),
    .AW_IN   (AW_IN),
    .AWREADY (AWREADY),
    .WVALID  (WVALID),
    .WLAST   (WLAST),
    .WDATA   (WDATA),
    .WREADY  (WREADY),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .BRESP   (BRESP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_start(input logic [7:0] a, input logic [3:0] id);
    int k = 0;
    AWVALID = 1'b1;
    AW_IN   = {a, id};
    while (!AWREADY && k < 100) begin tick(); k++; end
    chk("aw_ready_wait", 32'(AWREADY), 1);
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic w_push(input logic [7:0] d, input logic last);
    int k = 0;
    WVALID = 1'b1;
    WDATA  = d;
    WLAST  = last;
    while (!WREADY && k < 100) begin tick(); k++; end
    chk("w_ready_wait", 32'(WREADY), 1);
    tick();
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic b_finish(input logic [4:0] exp);
    int k = 0;
    while (!BVALID && k < 100) begin tick(); k++; end
    chk("b_valid_wait", 32'(BVALID), 1);
    chk("bresp", 32'(BRESP), 32'(exp));
    tick();
    chk("bresp_hold", 32'({BVALID, BRESP}), 32'({1'b1, exp}));
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("b_done", 32'(BVALID), 0);
    chk("aw_ready_after_b", 32'(AWREADY), 1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [3:0] id, input int n,
                          input logic [7:0] d0, input logic [7:0] step,
                          input int gap_max, input logic [4:0] exp_bresp);
    logic [7:0] d;
    logic [7:0] wa;
    aw_start(a, id);
    for (int i = 0; i < n; i++) begin
      d = d0 + 8'(i) * step;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
      w_push(d, i == n - 1);
      if (i < 16) begin
        wa = a + 8'(i);
        model_mem[wa] = d;
      end
    end
    b_finish(exp_bresp);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [3:0] len, input logic [3:0] id,
                         input int stall_beat, input int stall_n, input int rand_max,
                         output logic last_resp);
    int k = 0;
    int stall;
    logic [7:0] ba;
    logic [7:0] ed;
    logic er;
    logic el;
    last_resp = 1'bx;
    ARVALID = 1'b1;
    AR_IN   = {a, len, id};
    while (!ARREADY && k < 100) begin tick(); k++; end
    chk("ar_ready_wait", 32'(ARREADY), 1);
    tick();
    ARVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      ba = a + 8'(i);
      ed = model_mem[ba];
      er = (int'(a) + i) > 255;
      el = (i == int'(len));
      chk("r_valid", 32'(RVALID), 1);
      chk("r_data", 32'(R_OUT[8:1]), 32'(ed));
      chk("r_resp", 32'(R_OUT[0]), 32'(er));
      chk("r_last", 32'(RLAST), 32'(el));
      if (el) last_resp = R_OUT[0];
      stall = (i == stall_beat) ? stall_n : ((rand_max > 0) ? int'($urandom_range(0, rand_max)) : 0);
      repeat (stall) begin
        tick();
        chk("r_hold", 32'({RVALID, RLAST, R_OUT}), 32'({1'b1, el, ed, er}));
      end
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
    end
    chk("r_idle", 32'(RVALID), 0);
    chk("ar_ready_after_r", 32'(ARREADY), 1);
  endtask

  initial begin
    vec_t       tbl [5];
    logic       lr;
    logic [7:0] ra;
    logic [3:0] rid;
    int         rn;

    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    tbl[0] = '{8'h20, 4'hA, 4,  8'h11, 8'h11, 4'd3,  5'b1010_0, 1'b0};
    tbl[1] = '{8'hFE, 4'h2, 4,  8'hA0, 8'h01, 4'd3,  5'b0010_0, 1'b1};
    tbl[2] = '{8'h40, 4'h7, 18, 8'h01, 8'h01, 4'd15, 5'b0111_1, 1'b0};
    tbl[3] = '{8'hF8, 4'hF, 16, 8'h80, 8'h03, 4'd15, 5'b1111_0, 1'b1};
    tbl[4] = '{8'h00, 4'h0, 1,  8'h5C, 8'h00, 4'd0,  5'b0000_0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", 32'(ARREADY), 1);
    chk("rst_awready", 32'(AWREADY), 1);
    chk("rst_rvalid",  32'(RVALID), 0);
    chk("rst_rlast",   32'(RLAST), 0);
    chk("rst_rout",    32'(R_OUT), 0);
    chk("rst_wready",  32'(WREADY), 0);
    chk("rst_bvalid",  32'(BVALID), 0);
    chk("rst_bresp",   32'(BRESP), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      do_write(tbl[i].addr, tbl[i].id, tbl[i].n, tbl[i].d0, tbl[i].step, 0, tbl[i].exp_bresp);
      do_read(tbl[i].addr, tbl[i].rlen, tbl[i].id, -1, 0, 0, lr);
      chk("tbl_rresp_last", 32'(lr), 32'(tbl[i].exp_rresp_last));
      if (tbl[i].n > 16) do_read(tbl[i].addr + 8'd16, 4'd1, 4'h0, -1, 0, 0, lr);
    end

    // Backpressure: beat 2 held for three cycles
    do_read(8'h20, 4'd3, 4'h1, 1, 3, 0, lr);

    // Reset in the middle of a read burst and a write burst
    aw_start(8'h70, 4'h1);
    w_push(8'hE1, 1'b0); model_mem[8'h70] = 8'hE1;
    w_push(8'hE2, 1'b0); model_mem[8'h71] = 8'hE2;
    ARVALID = 1'b1;
    AR_IN   = 16'h10_3_5;
    chk("mr_arready", 32'(ARREADY), 1);
    tick();
    ARVALID = 1'b0;
    chk("mr_beat1", 32'({RVALID, R_OUT[8:1]}), 32'({1'b1, model_mem[8'h10]}));
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    rst = 1'b1;
    #1;
    chk("mr_rvalid",  32'(RVALID), 0);
    chk("mr_rlast",   32'(RLAST), 0);
    chk("mr_arready", 32'(ARREADY), 1);
    chk("mr_awready", 32'(AWREADY), 1);
    chk("mr_wready",  32'(WREADY), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    RREADY = 1'b1;
    BREADY = 1'b1;
    repeat (4) begin
      tick();
      chk("mr_no_rbeat", 32'(RVALID), 0);
      chk("mr_no_bresp", 32'(BVALID), 0);
    end
    RREADY = 1'b0;
    BREADY = 1'b0;
    chk("mr_arready_after", 32'(ARREADY), 1);
    do_read(8'h70, 4'd3, 4'h0, -1, 0, 0, lr);

    // AR and AW on the same cycle to 0x30
    do_write(8'h30, 4'h3, 1, 8'h5A, 8'h00, 0, 5'b0011_0);
    ARVALID = 1'b1; AR_IN = {8'h30, 4'h0, 4'h4};
    AWVALID = 1'b1; AW_IN = {8'h30, 4'h6};
    chk("cc_arready", 32'(ARREADY), 1);
    chk("cc_awready", 32'(AWREADY), 1);
    tick();
    ARVALID = 1'b0;
    AWVALID = 1'b0;
    chk("cc_rdata0", 32'({RVALID, R_OUT[8:1]}), 32'({1'b1, model_mem[8'h30]}));
    chk("cc_wready", 32'(WREADY), 1);
    WVALID = 1'b1; WDATA = 8'hC3; WLAST = 1'b1;
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
    chk("cc_rdata_hold", 32'(R_OUT[8:1]), 32'(model_mem[8'h30]));
    model_mem[8'h30] = 8'hC3;
    chk("cc_bresp", 32'({BVALID, BRESP}), 32'({1'b1, 5'b0110_0}));
    RREADY = 1'b1; BREADY = 1'b1;
    tick();
    RREADY = 1'b0; BREADY = 1'b0;
    chk("cc_r_done", 32'(RVALID), 0);
    chk("cc_b_done", 32'(BVALID), 0);
    do_read(8'h30, 4'd0, 4'h4, -1, 0, 0, lr);

    // Write beat and read fetch to 0x60 on the very same edge
    do_write(8'h60, 4'h2, 1, 8'h11, 8'h00, 0, 5'b0010_0);
    aw_start(8'h60, 4'h9);
    WVALID  = 1'b1; WDATA = 8'h77; WLAST = 1'b1;
    ARVALID = 1'b1; AR_IN = {8'h60, 4'h0, 4'h1};
    chk("col_arready", 32'(ARREADY), 1);
    chk("col_wready",  32'(WREADY), 1);
    tick();
    WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
    chk("col_rdata_old", 32'({RVALID, R_OUT[8:1]}), 32'({1'b1, model_mem[8'h60]}));
    model_mem[8'h60] = 8'h77;
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    b_finish(5'b1001_0);
    do_read(8'h60, 4'd0, 4'h1, -1, 0, 0, lr);

    // Randomized traffic against the byte-array model
    for (int t = 0; t < 30; t++) begin
      ra  = 8'($urandom);
      rid = 4'($urandom);
      rn  = int'($urandom_range(1, 18));
      do_write(ra, rid, rn, 8'($urandom), 8'($urandom_range(1, 255)), 2, {rid, rn > 16});
      if ($urandom_range(0, 1) == 1) ra = 8'($urandom);
      do_read(ra, 4'($urandom), 4'($urandom), -1, 0, 2, lr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire
